// File: rtl/register_file_if.sv
// Bus bundle for register_file: two read ports, one write-back port, an issue port
// for the pending-result scoreboard, and its status outputs.
interface register_file_if #(
   parameter int N  = 32,
   parameter int AW = 5
);
   logic [AW-1:0] ra1;
   logic [N-1:0]  rd1;
   logic [AW-1:0] ra2;
   logic [N-1:0]  rd2;
   logic          we;
   logic [AW-1:0] wa;
   logic [N-1:0]  wd;
   logic          iss_en;
   logic [AW-1:0] iss_rd;
   logic          haz1;
   logic          haz2;
   logic          waw_err;
   logic [AW:0]   pend_cnt;

   modport master (
      output ra1, ra2, we, wa, wd, iss_en, iss_rd,
      input  rd1, rd2, haz1, haz2, waw_err, pend_cnt
   );

   modport slave (
      input  ra1, ra2, we, wa, wd, iss_en, iss_rd,
      output rd1, rd2, haz1, haz2, waw_err, pend_cnt
   );
endinterface

// File: rtl/register_file.sv
// 2R1W register file with write-through bypass and a per-register pending-result
// scoreboard that reports RAW hazards, WAW issue errors and a pending count.
module register_file #(
   parameter int N  = 32,
   parameter int AW = 5
) (
   input logic            clk,
   input logic            rst,
   register_file_if.slave bus
);
   localparam int NR = 2 ** AW;

   logic [N-1:0]  regs [NR];
   logic [NR-1:0] pending;
   logic [NR-1:0] pend_next;
   logic [AW:0]   cnt_next;
   logic [AW:0]   pend_cnt_q;
   logic          wr_ok;
   logic          iss_ok;

   assign wr_ok  = bus.we && (bus.wa != '0);
   assign iss_ok = bus.iss_en && (bus.iss_rd != '0);

   // NOTE: every variable assigned here gets a default first, so no path leaves a latch.
   always_comb begin
      pend_next = pending;
      if (wr_ok)  pend_next[bus.wa]     = 1'b0;
      // Applied after the clear so an issue to the register being written back wins.
      if (iss_ok) pend_next[bus.iss_rd] = 1'b1;
      pend_next[0] = 1'b0;
      cnt_next = '0;
      for (int i = 0; i < NR; i++) begin
         cnt_next = cnt_next + {{AW{1'b0}}, pend_next[i]};
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the array is reset because reads must return 0 after reset; this keeps it in flops, not RAM.
         for (int i = 0; i < NR; i++) begin
            regs[i] <= '0;
         end
         pending    <= '0;
         pend_cnt_q <= '0;
      end else begin
         if (wr_ok) regs[bus.wa] <= bus.wd;
         pending    <= pend_next;
         pend_cnt_q <= cnt_next;
      end
   end

   always_comb begin
      bus.rd1 = '0;
      if (!rst && bus.ra1 != '0) begin
         if (wr_ok && bus.wa == bus.ra1) bus.rd1 = bus.wd;
         else                            bus.rd1 = regs[bus.ra1];
      end
   end

   always_comb begin
      bus.rd2 = '0;
      if (!rst && bus.ra2 != '0) begin
         if (wr_ok && bus.wa == bus.ra2) bus.rd2 = bus.wd;
         else                            bus.rd2 = regs[bus.ra2];
      end
   end

   // A write-back landing this cycle resolves the hazard it would otherwise report.
   assign bus.haz1 = !rst && (bus.ra1 != '0) && pending[bus.ra1]
                     && !(bus.we && bus.wa == bus.ra1);
   assign bus.haz2 = !rst && (bus.ra2 != '0) && pending[bus.ra2]
                     && !(bus.we && bus.wa == bus.ra2);

   assign bus.waw_err = !rst && iss_ok && pending[bus.iss_rd]
                        && !(bus.we && bus.wa == bus.iss_rd);

   assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: storage, bypass, r0 behaviour, scoreboard
// hazards, WAW flag, pending count and asynchronous reset.
module tb_register_file;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   register_file_if #(.N(32), .AW(5)) bus ();

   register_file #(.N(32), .AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we     = 1'b0;
      bus.wa     = '0;
      bus.wd     = '0;
      bus.iss_en = 1'b0;
      bus.iss_rd = '0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      bus.ra1 = '0;
      bus.ra2 = '0;

      // Writes, issues and bypass are all suppressed while reset is held.
      #2;
      bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hAAAA_5555;
      bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
      bus.ra1 = 5'd3; bus.ra2 = 5'd3;
      #1;
      check("rst_rd1", bus.rd1, 32'h0);
      check("rst_haz2", {31'b0, bus.haz2}, 32'h0);
      check("rst_waw", {31'b0, bus.waw_err}, 32'h0);
      tick();
      check("rst_cnt", {26'b0, bus.pend_cnt}, 32'h0);
      rst = 1'b0;
      idle();
      #1;
      check("rst_wr_ignored", bus.rd1, 32'h0);
      check("rst_iss_ignored", {31'b0, bus.haz1}, 32'h0);

      // Stored write, then same-cycle bypass on both ports at the same address.
      bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEAD_BEEF;
      tick();
      idle();
      bus.ra1 = 5'd5;
      #1;
      check("rd1_r5", bus.rd1, 32'hDEAD_BEEF);
      bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h0000_1234; bus.ra2 = 5'd5;
      #1;
      check("byp_rd2", bus.rd2, 32'h0000_1234);
      check("byp_rd1_same", bus.rd1, 32'h0000_1234);
      tick();
      idle();
      #1;
      check("rd1_r5_new", bus.rd1, 32'h0000_1234);

      // r0 is hardwired to zero, even against a bypassing write.
      bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFF_FFFF; bus.ra1 = 5'd0;
      #1;
      check("r0_byp", bus.rd1, 32'h0);
      tick();
      idle();
      #1;
      check("r0_later", bus.rd1, 32'h0);

      // RAW hazard on r7, cleared by a same-cycle write-back.
      bus.iss_en = 1'b1; bus.iss_rd = 5'd7;
      tick();
      idle();
      bus.ra1 = 5'd7; bus.ra2 = 5'd7;
      #1;
      check("haz1_r7", {31'b0, bus.haz1}, 32'h1);
      check("haz2_r7", {31'b0, bus.haz2}, 32'h1);
      check("cnt_1", {26'b0, bus.pend_cnt}, 32'h1);
      bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0000_0077;
      #1;
      check("haz1_wb", {31'b0, bus.haz1}, 32'h0);
      check("rd1_wb_byp", bus.rd1, 32'h0000_0077);
      check("cnt_still_1", {26'b0, bus.pend_cnt}, 32'h1);
      tick();
      idle();
      #1;
      check("cnt_0", {26'b0, bus.pend_cnt}, 32'h0);
      check("haz1_gone", {31'b0, bus.haz1}, 32'h0);

      // Issue to r0 never becomes pending.
      bus.iss_en = 1'b1; bus.iss_rd = 5'd0; bus.ra1 = 5'd0;
      #1;
      check("waw_r0", {31'b0, bus.waw_err}, 32'h0);
      tick();
      idle();
      #1;
      check("haz_r0", {31'b0, bus.haz1}, 32'h0);
      check("cnt_r0", {26'b0, bus.pend_cnt}, 32'h0);

      // WAW flag on r9; a concurrent write-back masks it and the set wins.
      bus.iss_en = 1'b1; bus.iss_rd = 5'd9;
      tick();
      #1;
      check("waw_r9", {31'b0, bus.waw_err}, 32'h1);
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h0000_0009;
      #1;
      check("waw_masked", {31'b0, bus.waw_err}, 32'h0);
      tick();
      idle();
      bus.ra1 = 5'd9;
      #1;
      check("r9_still_pend", {31'b0, bus.haz1}, 32'h1);
      check("cnt_r9", {26'b0, bus.pend_cnt}, 32'h1);
      bus.we = 1'b1; bus.wa = 5'd9;
      tick();
      idle();
      #1;
      check("cnt_r9_clr", {26'b0, bus.pend_cnt}, 32'h0);

      // Three pending registers, then reset asserted between edges.
      bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
      tick();
      bus.iss_rd = 5'd4;
      tick();
      bus.iss_rd = 5'd5;
      tick();
      idle();
      bus.ra1 = 5'd4; bus.ra2 = 5'd5;
      #1;
      check("cnt_3", {26'b0, bus.pend_cnt}, 32'h3);
      check("haz1_r4", {31'b0, bus.haz1}, 32'h1);
      check("haz2_r5", {31'b0, bus.haz2}, 32'h1);
      rst = 1'b1;
      #1;
      check("async_cnt", {26'b0, bus.pend_cnt}, 32'h0);
      check("async_haz1", {31'b0, bus.haz1}, 32'h0);
      check("async_haz2", {31'b0, bus.haz2}, 32'h0);
      check("async_rd2", bus.rd2, 32'h0);
      rst = 1'b0;
      #1;
      check("post_rd2", bus.rd2, 32'h0);
      tick();
      check("post_cnt", {26'b0, bus.pend_cnt}, 32'h0);
      check("post_haz2", {31'b0, bus.haz2}, 32'h0);

      // Normal operation resumes after reset.
      bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h0000_0044;
      tick();
      idle();
      #1;
      check("post_wr_r4", bus.rd1, 32'h0000_0044);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 32, data width of each register.
REQ-002 Parameter AW, default 5, address width; register count is 2**AW (32).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ra1  input  AW  read address, port 1.
REQ-006 rd1  output  N  read data, port 1.
REQ-007 ra2  input  AW  read address, port 2.
REQ-008 rd2  output  N  read data, port 2.
REQ-009 we  input  1  write-back enable.
REQ-010 wa  input  AW  write-back address.
REQ-011 wd  input  N  write-back data.
REQ-012 iss_en  input  1  issue strobe; marks iss_rd as pending.
REQ-013 iss_rd  input  AW  destination register of the issued instruction.
REQ-014 haz1  output  1  port-1 source has a pending, not-yet-written result.
REQ-015 haz2  output  1  port-2 source has a pending, not-yet-written result.
REQ-016 waw_err  output  1  issue to an already-pending register (protocol error flag).
REQ-017 pend_cnt  output  AW+1  number of registers currently pending (registered).

Function
REQ-018 Storage SHALL be 2**AW registers of N bits; register 0 SHALL always read 0.
REQ-019 Writes SHALL occur on rising clk when we=1 and wa!=0; writes with wa=0 SHALL be ignored.
REQ-020 Reads SHALL be combinational (zero-cycle latency).
REQ-021 Write-through bypass: if we=1, wa!=0 and wa==raX, rdX SHALL equal wd in the same cycle.
REQ-022 Scoreboard: one pending bit per register; bit 0 SHALL be constant 0.
REQ-023 On rising clk, pending[wa] SHALL clear when we=1 and wa!=0.
REQ-024 On rising clk, pending[iss_rd] SHALL set when iss_en=1 and iss_rd!=0.
REQ-025 Simultaneous set and clear of the same register: set SHALL win (bit ends 1).
REQ-026 hazX SHALL be 1 iff raX!=0, pending[raX]=1, and not (we=1 and wa==raX).
REQ-027 waw_err SHALL be 1 iff iss_en=1, iss_rd!=0, pending[iss_rd]=1, and not (we=1 and wa==iss_rd); combinational, the pending bit stays 1.
REQ-028 pend_cnt SHALL equal the popcount of the pending bits after each clock edge (registered, 1-cycle update); range 0..2**AW-1.
REQ-029 Bypass and hazard evaluation SHALL be independent per port; ra1==ra2 SHALL give identical rd/haz on both ports.

Reset
REQ-030 rst=1 SHALL asynchronously clear all registers to 0, all pending bits to 0 and pend_cnt to 0.
REQ-031 While rst=1, writes and issues SHALL be ignored; haz1, haz2 and waw_err SHALL be 0; rd1 and rd2 SHALL read 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending state; the first edge after release SHALL behave as post-reset.

Verification
REQ-033 Write r5=0xDEADBEEF, next cycle ra1=5 -> rd1=0xDEADBEEF; same-cycle we/wa=5/ra2=5 with wd=0x1234 -> rd2=0x1234.
REQ-034 we=1, wa=0, wd=0xFFFFFFFF; ra1=0 -> rd1=0, and r0 remains 0 on later reads.
REQ-035 iss_en, iss_rd=7; next cycle ra1=7 -> haz1=1, pend_cnt=1; then we, wa=7 -> haz1=0 in that cycle and pend_cnt=0 one cycle later.
REQ-036 r9 pending, iss_en, iss_rd=9 with we=0 -> waw_err=1; with we=1, wa=9 same cycle -> waw_err=0 and pending[9] stays 1.
REQ-037 Set pending on r3, r4, r5 (pend_cnt=3), assert rst between clk edges -> immediately pend_cnt=0, haz=0, all reads 0.
